hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I basic pipeline processor. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their stall (hold) and flush (bubble) controls. It resolves three conditions:
- load-use data hazards between EX and ID;
- taken-branch/jump redirects resolved in EX;
- multi-cycle data-memory accesses signalled by a ready handshake.

It also keeps saturating stall/flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1 (0 for LUI/AUIPC/JAL)
- id_use_rs2  in  1  ID instruction reads rs2 (R, S, B types only)
- ex_rd  in  5  destination register of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR
- mem_req  in  1  MEM-stage instruction is accessing data memory
- dmem_ready  in  1  data memory completes access this cycle
- stall_pc  out  1  hold PC
- stall_ifid  out  1  hold IF/ID
- stall_idex  out  1  hold ID/EX
- stall_exmem  out  1  hold EX/MEM
- flush_ifid  out  1  load NOP into IF/ID
- flush_idex  out  1  load NOP into ID/EX
- flush_memwb  out  1  load NOP into MEM/WB
- stall_count  out  CNT_W  cycles with stall_pc=1, saturating
- flush_count  out  CNT_W  redirect events, saturating

## Operation
- States: RUN, MEM_WAIT.
- State RUN → MEM_WAIT when mem_req=1 and dmem_ready=0.
- State MEM_WAIT → RUN on the cycle dmem_ready=1.
- Memory-wait condition mw: (state==RUN & mem_req & !dmem_ready) | (state==MEM_WAIT & !dmem_ready).
  - Outputs while mw: all four stall_* = 1, flush_memwb = 1 (no writeback of incomplete access), other flushes 0.
- Redirect condition, taken only when !mw and ex_redirect=1:
  - flush_ifid = 1 and flush_idex = 1; no stalls.
  - The PC loads the target in the same edge.
- Load-use condition, taken only when !mw, !ex_redirect, ex_mem_read=1 and ex_rd≠0:
  - Triggered when (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd).
  - stall_pc = 1, stall_ifid = 1 and flush_idex = 1, giving exactly one bubble.
  - Because the load moves to MEM, the condition clears on the next cycle by itself; no extra state is needed.
- Priority: mw > redirect > load-use. A redirect concurrent with load-use discards the wrong-path ID instruction, so no stall is applied.
- During mw, EX is frozen, so a pending ex_redirect stays asserted. It takes effect on the first cycle after dmem_ready.
- ex_rd = x0 never creates a hazard.
- Counters:
  - stall_count increments every cycle stall_pc=1.
  - flush_count increments every redirect cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- All hazard outputs are combinational from the current state and inputs, valid in the same cycle.
- State and counters update on the rising clk edge.
- Load-use costs 1 cycle. A redirect costs 2 bubbles. A memory access with N wait cycles costs N cycles.
- mem_req and dmem_ready both 1 in RUN is a zero-wait access: no stall, state stays RUN.
- reset=1 at an edge:
  - state → RUN, both counters → 0.
  - While reset is high: all stall_* = 0, flush_ifid = flush_idex = flush_memwb = 1, so the pipeline fills with NOPs.
- reset asserted in MEM_WAIT aborts the wait. The next non-reset cycle starts in RUN.
- Inputs must be stable before the edge. The block contains no combinational path from any output back to its own inputs.

## Structure
- Shared package: state encoding (RUN=1'b0, MEM_WAIT=1'b1), REG_X0 constant (5'd0), NOP encoding (32'h00000013) used by the pipeline registers on flush.
- One natural sub-module: sat_counter (parameter W; ports clk, reset, inc, count), instantiated twice.
- Hazard detection and priority mux stay flat in hazard_ctrl.

## Test plan
- Reset: hold reset 2 cycles → flush_ifid/idex/memwb = 1, stalls = 0. After release, counters = 0 and all outputs = 0 with idle inputs.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → stall_pc=stall_ifid=flush_idex=1 that cycle only; stall_count=1. With ex_rd=0 → no stall.
- Redirect: ex_redirect=1 for one cycle → flush_ifid=flush_idex=1, flush_count=1. Concurrent with load-use → no stall_pc.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 → all stalls and flush_memwb = 1 for 3 cycles, 0 on the ready cycle; stall_count=3.
- Redirect during wait: ex_redirect=1 throughout a 2-cycle wait → no flush until the cycle after dmem_ready, then exactly one flush; flush_count=1.
- Saturation: CNT_W=4, stall for 20 cycles → stall_count = 15 and holds. Reset mid-wait → state RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the RV32I pipeline hazard
//               controller: FSM state encoding, x0 register index, and the
//               NOP instruction loaded by pipeline registers on flush.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hc_state_e;

  // Register x0 is hard-wired to zero and never carries a dependency
  localparam logic [4:0]  REG_X0    = 5'd0;

  // ADDI x0, x0, 0 -- the bubble a flushed pipeline register holds
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when an ID source operand is actually read and names register rd
  function automatic logic reads_reg(input logic       use_f,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_f && (rs == rd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count qualifying cycles, holding once the maximum value is reached
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush controller for a 5-stage RV32I pipeline. Resolves
//               data-memory wait states, EX-stage redirects and load-use
//               hazards (in that priority) and keeps saturating performance
//               counters of stalled cycles and redirect events.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_memwb,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hc_state_e state_q;
  hc_state_e state_d;

  logic w_mem_wait;
  logic w_redirect;
  logic w_load_use;

  // State register; reset abandons any outstanding memory wait
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Hazard detection, next state and prioritised stall/flush controls
  always_comb begin
    state_d     = state_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;

    // Waiting on data memory: a new access that is not ready, or an
    // access already in progress that is still not ready.
    w_mem_wait = ((state_q == ST_RUN) && mem_req && !dmem_ready) ||
                 ((state_q == ST_MEM_WAIT) && !dmem_ready);

    // EX is frozen during a wait, so a redirect is only acted on once the
    // wait ends; it is held asserted by EX until then.
    w_redirect = !w_mem_wait && ex_redirect;

    // A redirect discards the ID instruction, so a load-use stall on it
    // would only waste a cycle.
    w_load_use = !w_mem_wait && !ex_redirect && ex_mem_read &&
                 (ex_rd != REG_X0) &&
                 (reads_reg(id_use_rs1, id_rs1, ex_rd) ||
                  reads_reg(id_use_rs2, id_rs2, ex_rd));

    case (state_q)
      ST_RUN:      if (mem_req && !dmem_ready) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (dmem_ready)             state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    if (reset) begin
      // Fill the front and back of the pipeline with NOPs
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_memwb = 1'b1;
    end else if (w_mem_wait) begin
      // Freeze everything upstream; the incomplete access must not retire
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else if (w_redirect) begin
      // PC takes the target this edge; squash the two wrong-path slots
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end else if (w_load_use) begin
      // Hold fetch/decode one cycle and inject a single bubble into EX
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      flush_idex  = 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_pc),
    .count (stall_count)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed vector table,
//               hand-written multi-cycle sequences and randomized traffic
//               compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic       mem_req, dmem_ready;

  logic        s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb;
  logic [15:0] stall_cnt16, flush_cnt16;
  logic        t_pc, t_ifid, t_idex, t_exmem, tf_ifid, tf_idex, tf_memwb;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .stall_pc(s_pc), .stall_ifid(s_ifid),
    .stall_idex(s_idex), .stall_exmem(s_exmem), .flush_ifid(f_ifid),
    .flush_idex(f_idex), .flush_memwb(f_memwb), .stall_count(stall_cnt16),
    .flush_count(flush_cnt16)
  );

  hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .stall_pc(t_pc), .stall_ifid(t_ifid),
    .stall_idex(t_idex), .stall_exmem(t_exmem), .flush_ifid(tf_ifid),
    .flush_idex(tf_idex), .flush_memwb(tf_memwb), .stall_count(stall_cnt4),
    .flush_count(flush_cnt4)
  );

  wire [6:0] act16 = {s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb};
  wire [6:0] act4  = {t_pc, t_ifid, t_idex, t_exmem, tf_ifid, tf_idex, tf_memwb};

  // Output patterns {stall pc,ifid,idex,exmem, flush ifid,idex,memwb}
  localparam logic [6:0] P_IDLE  = 7'b0000000;
  localparam logic [6:0] P_RESET = 7'b0000111;
  localparam logic [6:0] P_WAIT  = 7'b1111001;
  localparam logic [6:0] P_REDIR = 7'b0000110;
  localparam logic [6:0] P_LU    = 7'b1100010;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_wait;
  int m_stall16, m_flush16, m_stall4, m_flush4;

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, redir;
    logic [6:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected controls from the rules: reset, then memory wait, redirect, load-use
  function automatic logic [6:0] model_outs(input bit mw);
    if (reset) return P_RESET;
    if (mw) return P_WAIT;
    if (ex_redirect) return P_REDIR;
    if (ex_mem_read && ex_rd != 5'd0 &&
        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)))
      return P_LU;
    return P_IDLE;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge
  task automatic cycle(input string name, input bit use_tbl, input logic [6:0] tbl_exp);
    bit mw;
    logic [6:0] e;
    @(negedge clk);
    mw = !reset && !dmem_ready && (m_wait || mem_req);
    e  = model_outs(mw);
    check({name, "/outs"}, {25'd0, act16}, {25'd0, e});
    check({name, "/outs_w4"}, {25'd0, act4}, {25'd0, e});
    if (use_tbl) check({name, "/table"}, {25'd0, act16}, {25'd0, tbl_exp});
    check({name, "/stall_cnt"}, {16'd0, stall_cnt16}, m_stall16);
    check({name, "/flush_cnt"}, {16'd0, flush_cnt16}, m_flush16);
    check({name, "/stall_cnt_w4"}, {28'd0, stall_cnt4}, m_stall4);
    check({name, "/flush_cnt_w4"}, {28'd0, flush_cnt4}, m_flush4);
    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    end else begin
      m_wait = mw;
      if (e[6]) begin
        m_stall16 = sat_inc(m_stall16, 65535);
        m_stall4  = sat_inc(m_stall4, 15);
      end
      if (!mw && ex_redirect) begin
        m_flush16 = sat_inc(m_flush16, 65535);
        m_flush4  = sat_inc(m_flush4, 15);
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; mem_req = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle("reset", 1, P_RESET);
    cycle("reset", 1, P_RESET);
    reset = 0;
  endtask

  vec_t tbl [10];

  initial begin
    m_wait = 0; m_stall16 = 0; m_flush16 = 0; m_stall4 = 0; m_flush4 = 0;
    tbl[0] = '{5'd0,  5'd0,  5'd0,  0, 0, 0, 0, P_IDLE};
    tbl[1] = '{5'd3,  5'd5,  5'd5,  0, 1, 1, 0, P_LU};
    tbl[2] = '{5'd0,  5'd0,  5'd0,  1, 1, 1, 0, P_IDLE};
    tbl[3] = '{5'd7,  5'd2,  5'd7,  1, 0, 1, 0, P_LU};
    tbl[4] = '{5'd7,  5'd2,  5'd7,  0, 1, 1, 0, P_IDLE};
    tbl[5] = '{5'd9,  5'd9,  5'd9,  1, 1, 0, 0, P_IDLE};
    tbl[6] = '{5'd1,  5'd2,  5'd3,  0, 0, 0, 1, P_REDIR};
    tbl[7] = '{5'd4,  5'd4,  5'd4,  1, 1, 1, 1, P_REDIR};
    tbl[8] = '{5'd6,  5'd8,  5'd8,  1, 0, 1, 0, P_IDLE};
    tbl[9] = '{5'd31, 5'd0,  5'd31, 1, 0, 1, 0, P_LU};

    // Reset and quiet state
    do_reset();
    cycle("post_reset_idle", 1, P_IDLE);
    check("post_reset_stall_cnt", {16'd0, stall_cnt16}, 0);

    // Directed vector table in RUN, no memory traffic
    for (int i = 0; i < 10; i++) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mr; ex_redirect = tbl[i].redir;
      cycle($sformatf("tbl%0d", i), 1, tbl[i].exp);
    end

    // Load-use costs exactly one stall cycle
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    cycle("lu", 1, P_LU);
    idle();
    cycle("lu_after", 1, P_IDLE);
    check("lu_stall_count", {16'd0, stall_cnt16}, 1);

    // Redirect, alone then concurrent with a load-use
    do_reset();
    ex_redirect = 1;
    cycle("redir", 1, P_REDIR);
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle("redir_lu", 1, P_REDIR);
    idle();
    cycle("redir_after", 1, P_IDLE);
    check("redir_flush_count", {16'd0, flush_cnt16}, 2);
    check("redir_stall_count", {16'd0, stall_cnt16}, 0);

    // Three wait cycles, then ready; also a zero-wait access
    do_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) cycle("mw", 1, P_WAIT);
    dmem_ready = 1;
    cycle("mw_ready", 1, P_IDLE);
    cycle("zero_wait", 1, P_IDLE);
    idle();
    cycle("mw_after", 1, P_IDLE);
    check("mw_stall_count", {16'd0, stall_cnt16}, 3);

    // Redirect held through a 2-cycle wait fires once, when the wait ends
    do_reset();
    mem_req = 1; dmem_ready = 0; ex_redirect = 1;
    cycle("mw_redir", 1, P_WAIT);
    mem_req = 0;
    cycle("mw_redir", 1, P_WAIT);
    check("mw_redir_no_flush", {16'd0, flush_cnt16}, 0);
    dmem_ready = 1;
    cycle("mw_redir_ready", 1, P_REDIR);
    idle();
    cycle("mw_redir_after", 1, P_IDLE);
    check("mw_redir_flush_count", {16'd0, flush_cnt16}, 1);

    // Saturation of the narrow counter
    do_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 20; i++) cycle("sat", 1, P_WAIT);
    dmem_ready = 1;
    cycle("sat_ready", 1, P_IDLE);
    idle();
    cycle("sat_after", 1, P_IDLE);
    check("sat_stall_count_w4", {28'd0, stall_cnt4}, 15);
    check("sat_stall_count_w16", {16'd0, stall_cnt16}, 20);

    // Reset while waiting returns to RUN with cleared counters
    mem_req = 1; dmem_ready = 0;
    cycle("abort_wait", 1, P_WAIT);
    reset = 1;
    cycle("abort_reset", 1, P_RESET);
    idle();
    cycle("abort_after", 1, P_IDLE);
    check("abort_stall_count", {16'd0, stall_cnt16}, 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 40) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_req     = ($urandom_range(0, 3) == 0);
      dmem_ready  = ($urandom_range(0, 2) == 0);
      cycle("rand", 0, P_IDLE);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
